// File: rtl/seq_alu.sv
// Multi-cycle signed ALU (ADD/SUB/MUL/DIV) with valid/ready handshakes on both sides.
// Define SEQ_ALU_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module seq_alu #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           S,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic                 ZF,
  output logic                 SF,
  output logic                 DZF
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // x: multiplier bits / dividend shifting into quotient
  // y: shifted multiplicand / divisor; acc: product sum / partial remainder
  logic [WIDTH-1:0] x_q, x_d;
  logic [RW-1:0]   y_q, y_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   r_q, r_d;
  logic            zf_q, zf_d;
  logic            sf_q, sf_d;
  logic            dzf_q, dzf_d;
  logic            out_valid_q, out_valid_d;

  logic [RW-1:0]    a_ext, b_ext, res, mag, rem_sh;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             fin, dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      dzf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      dzf_q       <= dzf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    r_d     = r_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    dzf_d   = dzf_q;
    res     = '0;
    mag     = '0;
    rem_sh  = '0;
    fin     = 1'b0;
    dz      = 1'b0;
    a_ext   = {{WIDTH{A[WIDTH-1]}}, A};
    b_ext   = {{WIDTH{B[WIDTH-1]}}, B};
    a_mag   = A[WIDTH-1] ? WIDTH'(WIDTH'(0) - A) : A;
    b_mag   = B[WIDTH-1] ? WIDTH'(WIDTH'(0) - B) : B;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = S;
          neg_d = A[WIDTH-1] ^ B[WIDTH-1];
          cnt_d = '0;
          acc_d = '0;
          unique case (S)
            OP_ADD: begin
              res = RW'(a_ext + b_ext);
              fin = 1'b1;
            end
            OP_SUB: begin
              res = RW'(a_ext - b_ext);
              fin = 1'b1;
            end
            OP_DIV: begin
              if (B == '0) begin
                dz  = 1'b1;
                fin = 1'b1;
              end else begin
                x_d     = a_mag;
                y_d     = RW'(b_mag);
                state_d = ST_CALC;
              end
            end
            OP_MUL: begin
`ifdef SEQ_ALU_FAST_MUL_EN
              res = RW'(a_ext * b_ext);
              fin = 1'b1;
`else
              x_d     = b_mag;
              y_d     = RW'(a_mag);
              state_d = ST_CALC;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        cnt_d = CW'(cnt_q + CW'(1));
        if (op_q == OP_DIV) begin
          // one restoring step: shift next dividend bit into the remainder
          rem_sh = {acc_q[RW-2:0], x_q[WIDTH-1]};
          x_d    = {x_q[WIDTH-2:0], 1'b0};
          if (rem_sh >= y_q) begin
            acc_d = RW'(rem_sh - y_q);
            x_d[0] = 1'b1;
          end else begin
            acc_d = rem_sh;
          end
          mag = RW'(x_d);
        end else begin
          if (x_q[0]) acc_d = RW'(acc_q + y_q);
          y_d = {y_q[RW-2:0], 1'b0};
          x_d = {1'b0, x_q[WIDTH-1:1]};
          mag = acc_d;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          res = neg_q ? RW'(RW'(0) - mag) : mag;
          fin = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d = ST_DONE;
      r_d     = res;
      zf_d    = (res == '0);
      sf_d    = res[RW-1];
      dzf_d   = dz;
    end
    out_valid_d = (state_d == ST_DONE);
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign ZF        = zf_q;
  assign SF        = sf_q;
  assign DZF       = dzf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed checks of seq_alu against an integer-arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W  = 3;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    S = '0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] R;
  logic          ZF, SF, DZF;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .ZF(ZF), .SF(SF), .DZF(DZF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic, truncating division
  function automatic void model(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [RW-1:0] r, output logic dz, output int lat);
    int sa, sb, res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    dz  = 1'b0;
    lat = 1;
    res = 0;
    case (s)
      2'b00: res = sa + sb;
      2'b11: res = sa - sb;
      2'b10: begin
        res = sa * sb;
`ifndef SEQ_ALU_FAST_MUL_EN
        lat = W + 1;
`endif
      end
      default: begin
        if (sb == 0) dz = 1'b1;
        else begin
          res = sa / sb;
          lat = W + 1;
        end
      end
    endcase
    r = RW'(res);
  endfunction

  task automatic do_op(input string tag, input logic [1:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    logic [RW-1:0] er;
    logic          edz;
    int            elat, lat;
    model(s, a, b, er, edz, elat);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
    S = s; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; S = 2'($urandom); A = W'($urandom); B = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".R"}, 64'(R), 64'(er));
    check({tag, ".ZF"}, 64'(ZF), 64'(er == '0));
    check({tag, ".SF"}, 64'(SF), 64'(er[RW-1]));
    check({tag, ".DZF"}, 64'(DZF), 64'(edz));
    // hold under backpressure while stray requests arrive
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1)); A = W'($urandom); B = W'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, ".hold_R"}, 64'(R), 64'(er));
      check({tag, ".hold_flags"}, 64'({ZF, SF, DZF}), 64'({er == '0, er[RW-1], edz}));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, ".rel_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, ".rel_out_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'(1));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.R", 64'(R), 64'(0));
    check("rst.flags", 64'({ZF, SF, DZF}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_3_m2", 2'b00, W'(3), W'(-2), 0);
    do_op("sub_2_m3", 2'b11, W'(2), W'(-3), 0);
    do_op("div_m3_2", 2'b01, W'(-3), W'(2), 0);
    do_op("div_3_0", 2'b01, W'(3), W'(0), 1);
    do_op("mul_m4_m4", 2'b10, W'(-4), W'(-4), 0);
    do_op("mul_m1_m2", 2'b10, W'(-1), W'(-2), 0);
    do_op("div_m4_m1", 2'b01, W'(-4), W'(-1), 0);
    do_op("sub_m4_3", 2'b11, W'(-4), W'(3), 0);
    do_op("add_bp", 2'b00, W'(2), W'(1), 5);

    // reset during the second CALC cycle of a MUL
    S = 2'b10; A = W'(-4); B = W'(3); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 64'(out_valid), 64'(0));
    check("abort.R", 64'(R), 64'(0));
    check("abort.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("add_1_1", 2'b00, W'(1), W'(1), 0);

    for (int n = 0; n < 60; n++) begin
      do_op("rand", 2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
